normal_mode: RTL and testbench

- Normal-operation sequencer for the two-lane intersection. Consumes the committed green/yellow/red durations produced by the configuration stage.
- Drives both lanes' R/Y/G lamps and per-lane countdown values through a four-phase cycle.
- Sits directly downstream of the configuration stage and is active when the shared mode bus selects normal mode.

---
 rtl/normal_mode.sv | 168 ++++++++++++++++
 tb/tb_normal_mode.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/normal_mode.sv
// Normal-operation sequencer for a two-lane intersection: walks G1R2 -> Y1R2 -> R1G2 -> R1Y2
// using durations latched at the start of each cycle, counting down once per prescaled tick.
module normal_mode #(
  parameter int          TICK_DIV    = 50000000,
  parameter int          DEF_GREEN   = 25,
  parameter int          DEF_YELLOW  = 5,
  parameter logic [2:0]  MODE_NORMAL = 3'b001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] enable,
  input  logic [6:0] greenTime,
  input  logic [6:0] yellowTime,
  input  logic [6:0] redTime,
  output logic [2:0] light1,
  output logic [2:0] light2,
  output logic [6:0] timeLane1,
  output logic [6:0] timeLane2,
  output logic [1:0] state
);

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]     DEF_G      = 7'(DEF_GREEN);
  localparam logic [6:0]     DEF_Y      = 7'(DEF_YELLOW);
  localparam logic [6:0]     DEF_R      = 7'(DEF_GREEN + DEF_YELLOW);

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;

  typedef enum logic [1:0] {
    G1R2 = 2'd0,
    Y1R2 = 2'd1,
    R1G2 = 2'd2,
    R1Y2 = 2'd3
  } phase_t;

  phase_t          phase_q, phase_d;
  logic            running_q, running_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      light1_q, light1_d, light2_q, light2_d;
  logic [6:0]      time1_q, time1_d, time2_q, time2_d;
  logic [6:0]      grn_q, grn_d, yel_q, yel_d, red_q, red_d;

  logic            in_valid;
  logic            tick;
  logic [6:0]      sel_g, sel_y, sel_r;

  function automatic logic in_range(input logic [6:0] v);
    return (v >= 7'd1) && (v <= 7'd99);
  endfunction

  // Red must equal green+yellow so lane 2's red expires on the same tick lane 1's yellow does.
  assign in_valid = in_range(greenTime) && in_range(yellowTime) && in_range(redTime) &&
                    (({1'b0, greenTime} + {1'b0, yellowTime}) == {1'b0, redTime});
  assign sel_g    = in_valid ? greenTime  : DEF_G;
  assign sel_y    = in_valid ? yellowTime : DEF_Y;
  assign sel_r    = in_valid ? redTime    : DEF_R;
  assign tick     = (presc_q == PRESC_LAST);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    phase_d   = phase_q;
    running_d = running_q;
    presc_d   = presc_q;
    light1_d  = light1_q;
    light2_d  = light2_q;
    time1_d   = time1_q;
    time2_d   = time2_q;
    grn_d     = grn_q;
    yel_d     = yel_q;
    red_d     = red_q;

    if (enable != MODE_NORMAL) begin
      running_d = 1'b0;
      phase_d   = G1R2;
      presc_d   = '0;
      light1_d  = LAMP_OFF;
      light2_d  = LAMP_OFF;
      time1_d   = 7'd0;
      time2_d   = 7'd0;
    end else if (!running_q) begin
      running_d = 1'b1;
      phase_d   = G1R2;
      presc_d   = '0;
      grn_d     = sel_g;
      yel_d     = sel_y;
      red_d     = sel_r;
      light1_d  = LAMP_G;
      light2_d  = LAMP_R;
      time1_d   = sel_g;
      time2_d   = sel_r;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (time1_q > 7'd1) time1_d = time1_q - 7'd1;
        if (time2_q > 7'd1) time2_d = time2_q - 7'd1;
        case (phase_q)
          G1R2: if (time1_q == 7'd1) begin
            phase_d  = Y1R2;
            light1_d = LAMP_Y;
            time1_d  = yel_q;
          end
          Y1R2: if (time1_q == 7'd1) begin
            phase_d  = R1G2;
            light1_d = LAMP_R;
            time1_d  = red_q;
            light2_d = LAMP_G;
            time2_d  = grn_q;
          end
          R1G2: if (time2_q == 7'd1) begin
            phase_d  = R1Y2;
            light2_d = LAMP_Y;
            time2_d  = yel_q;
          end
          R1Y2: if (time2_q == 7'd1) begin
            // Cycle boundary: the only point where new durations are accepted.
            phase_d  = G1R2;
            grn_d    = sel_g;
            yel_d    = sel_y;
            red_d    = sel_r;
            light1_d = LAMP_G;
            time1_d  = sel_g;
            light2_d = LAMP_R;
            time2_d  = sel_r;
          end
          default: phase_d = G1R2;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= G1R2;
      running_q <= 1'b0;
      presc_q   <= '0;
      light1_q  <= LAMP_OFF;
      light2_q  <= LAMP_OFF;
      time1_q   <= 7'd0;
      time2_q   <= 7'd0;
      grn_q     <= DEF_G;
      yel_q     <= DEF_Y;
      red_q     <= DEF_R;
    end else begin
      phase_q   <= phase_d;
      running_q <= running_d;
      presc_q   <= presc_d;
      light1_q  <= light1_d;
      light2_q  <= light2_d;
      time1_q   <= time1_d;
      time2_q   <= time2_d;
      grn_q     <= grn_d;
      yel_q     <= yel_d;
      red_q     <= red_d;
    end
  end

  assign light1    = light1_q;
  assign light2    = light2_q;
  assign timeLane1 = time1_q;
  assign timeLane2 = time2_q;
  assign state     = phase_q;

endmodule

// File: tb/tb_normal_mode.sv
// Bench for normal_mode (TICK_DIV=4): directed test-plan steps plus randomized durations,
// every cycle compared against a schedule model derived from elapsed time within the cycle.
module tb_normal_mode;

  localparam int TD = 4;

  logic       clk;
  logic       reset;
  logic [2:0] enable;
  logic [6:0] greenTime, yellowTime, redTime;
  logic [2:0] light1, light2;
  logic [6:0] timeLane1, timeLane2;
  logic [1:0] state;

  int vectors;
  int miscompares;

  normal_mode #(
    .TICK_DIV   (TD),
    .DEF_GREEN  (25),
    .DEF_YELLOW (5),
    .MODE_NORMAL(3'b001)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .greenTime (greenTime),
    .yellowTime(yellowTime),
    .redTime   (redTime),
    .light1    (light1),
    .light2    (light2),
    .timeLane1 (timeLane1),
    .timeLane2 (timeLane2),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: latched durations plus clocks elapsed since the current cycle began.
  int m_g, m_y, m_r;
  int m_n;
  bit m_run;

  task automatic m_latch();
    int g, y, r;
    g = int'(greenTime);
    y = int'(yellowTime);
    r = int'(redTime);
    if (g >= 1 && g <= 99 && y >= 1 && y <= 99 && r >= 1 && r <= 99 && r == g + y) begin
      m_g = g; m_y = y; m_r = r;
    end else begin
      m_g = 25; m_y = 5; m_r = 30;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 1'b0; m_n = 0; m_g = 25; m_y = 5; m_r = 30;
    end else if (enable != 3'b001) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1; m_n = 0; m_latch();
    end else begin
      m_n++;
      if (m_n == 2 * m_r * TD) begin
        m_n = 0;
        m_latch();
      end
    end
  end

  typedef struct {
    logic [1:0] st;
    logic [2:0] l1;
    logic [2:0] l2;
    logic [6:0] t1;
    logic [6:0] t2;
  } obs_t;

  // Lane 1 owns ticks [0, R) of the cycle (green then yellow), lane 2 owns [R, 2R).
  function automatic obs_t model_out();
    obs_t e;
    int   k;
    e = '{st: 2'd0, l1: 3'b000, l2: 3'b000, t1: 7'd0, t2: 7'd0};
    if (m_run) begin
      k = m_n / TD;
      if (k < m_g) begin
        e.st = 2'd0; e.l1 = 3'b001; e.l2 = 3'b100; e.t1 = 7'(m_g - k); e.t2 = 7'(m_r - k);
      end else if (k < m_r) begin
        e.st = 2'd1; e.l1 = 3'b010; e.l2 = 3'b100; e.t1 = 7'(m_r - k); e.t2 = 7'(m_r - k);
      end else if (k < m_r + m_g) begin
        e.st = 2'd2; e.l1 = 3'b100; e.l2 = 3'b001; e.t1 = 7'(2 * m_r - k); e.t2 = 7'(m_r + m_g - k);
      end else begin
        e.st = 2'd3; e.l1 = 3'b100; e.l2 = 3'b010; e.t1 = 7'(2 * m_r - k); e.t2 = 7'(2 * m_r - k);
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_model(input string tag);
    obs_t e;
    e = model_out();
    check({tag, ".state"}, 8'(state), 8'(e.st));
    check({tag, ".light1"}, 8'(light1), 8'(e.l1));
    check({tag, ".light2"}, 8'(light2), 8'(e.l2));
    check({tag, ".time1"}, 8'(timeLane1), 8'(e.t1));
    check({tag, ".time2"}, 8'(timeLane2), 8'(e.t2));
    if (light1 != 3'b000 || light2 != 3'b000)
      check({tag, ".one_lane_red"}, 8'(light1 == 3'b100 || light2 == 3'b100), 8'd1);
  endtask

  task automatic expect_now(input string tag, input logic [1:0] st, input logic [2:0] l1,
                            input logic [2:0] l2, input logic [6:0] t1, input logic [6:0] t2);
    check({tag, ".state"}, 8'(state), 8'(st));
    check({tag, ".light1"}, 8'(light1), 8'(l1));
    check({tag, ".light2"}, 8'(light2), 8'(l2));
    check({tag, ".time1"}, 8'(timeLane1), 8'(t1));
    check({tag, ".time2"}, 8'(timeLane2), 8'(t2));
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_model(tag);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, len;
    vectors = 0; miscompares = 0;
    reset = 1'b0; enable = 3'b000;
    greenTime = 7'd5; yellowTime = 7'd2; redTime = 7'd7;
    repeat (3) @(negedge clk);
    expect_now("reset", 2'd0, 3'b000, 3'b000, 7'd0, 7'd0);
    reset = 1'b1;
    run(2, "idle");

    // Nominal 5/2/7 cycle.
    enable = 3'b001;
    run(1, "start");
    expect_now("start", 2'd0, 3'b001, 3'b100, 7'd5, 7'd7);
    run(20, "nom");
    expect_now("y1r2", 2'd1, 3'b010, 3'b100, 7'd2, 7'd2);
    run(8, "nom");
    expect_now("r1g2", 2'd2, 3'b100, 3'b001, 7'd7, 7'd5);
    run(20, "nom");
    expect_now("r1y2", 2'd3, 3'b100, 3'b010, 7'd2, 7'd2);
    run(8, "nom");
    expect_now("wrap", 2'd0, 3'b001, 3'b100, 7'd5, 7'd7);
    run(3 * 56, "three_cycles");
    expect_now("after3", 2'd0, 3'b001, 3'b100, 7'd5, 7'd7);

    // Mid-cycle change only takes effect at the next G1R2 entry.
    run(22, "pre_change");
    expect_now("mid_y1", 2'd1, 3'b010, 3'b100, 7'd2, 7'd2);
    greenTime = 7'd10; redTime = 7'd12;
    run(33, "old_cycle");
    expect_now("old_end", 2'd3, 3'b100, 3'b010, 7'd1, 7'd1);
    run(1, "relatch");
    expect_now("relatch", 2'd0, 3'b001, 3'b100, 7'd10, 7'd12);

    // Exit at tick 3 of R1G2, then re-enter.
    run(62, "to_exit");
    expect_now("s2_t3", 2'd2, 3'b100, 3'b001, 7'd9, 7'd7);
    enable = 3'b010; greenTime = 7'd5; redTime = 7'd7;
    run(1, "exit");
    expect_now("exit", 2'd0, 3'b000, 3'b000, 7'd0, 7'd0);
    run(3, "idle2");
    enable = 3'b001;
    run(1, "reenter");
    expect_now("reenter", 2'd0, 3'b001, 3'b100, 7'd5, 7'd7);

    // Asynchronous reset pulse in R1Y2.
    run(50, "to_s3");
    expect_now("s3", 2'd3, 3'b100, 3'b010, 7'd2, 7'd2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 expect_now("async_clr", 2'd0, 3'b000, 3'b000, 7'd0, 7'd0);
    #1 reset = 1'b1;
    run(1, "post_reset");
    expect_now("post_reset", 2'd0, 3'b001, 3'b100, 7'd5, 7'd7);

    // Invalid duration sets fall back to 25/5/30.
    enable = 3'b000; redTime = 7'd9;
    run(2, "idle3");
    enable = 3'b001;
    run(1, "inv_r");
    expect_now("inv_r", 2'd0, 3'b001, 3'b100, 7'd25, 7'd30);
    enable = 3'b000; greenTime = 7'd0; redTime = 7'd7;
    run(2, "idle4");
    enable = 3'b001;
    run(1, "inv_g0");
    expect_now("inv_g0", 2'd0, 3'b001, 3'b100, 7'd25, 7'd30);
    run(130, "default_run");

    // Randomized duration sets, mid-run changes and mode drops.
    for (int it = 0; it < 8; it++) begin
      enable = 3'($urandom_range(7, 2));
      run(2, "rnd_idle");
      greenTime  = 7'($urandom_range(20, 1));
      yellowTime = 7'($urandom_range(6, 1));
      redTime    = greenTime + yellowTime;
      kind = int'($urandom_range(5, 0));
      if (kind == 0) redTime = redTime + 7'd1;
      else if (kind == 1) greenTime = 7'd0;
      else if (kind == 2) begin greenTime = 7'd100; redTime = 7'd102; yellowTime = 7'd2; end
      enable = 3'b001;
      len = int'($urandom_range(300, 20));
      run(len, "rnd_run");
      greenTime  = 7'($urandom_range(15, 1));
      yellowTime = 7'($urandom_range(5, 1));
      redTime    = greenTime + yellowTime;
      len = int'($urandom_range(300, 20));
      run(len, "rnd_change");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
